// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with write bypass and busy-bit scoreboard
// Reads are combinational; writes, reservations and the busy counter update on the rising edge.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rsv_en_i,
    input  logic [ADDR_W-1:0]          rsv_addr_i,
    output logic [ADDR_W:0]            busy_cnt_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic wr_hit;
    logic rsv_hit;
    logic busy_rise;
    logic busy_fall;

    assign wr_hit  = wr_en_i  && (wr_addr_i  != '0);
    assign rsv_hit = rsv_en_i && (rsv_addr_i != '0);

    // Counter delta follows real bit transitions so it always equals the popcount.
    assign busy_rise = rsv_hit && !busy_q[rsv_addr_i];
    assign busy_fall = wr_hit && busy_q[wr_addr_i] && !(rsv_hit && (rsv_addr_i == wr_addr_i));

    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (rsv_hit) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (busy_rise && !busy_fall) begin
            busy_cnt_d = busy_cnt_q + 1'b1;
        end else if (busy_fall && !busy_rise) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        logic              byp;

        assign rd_a = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign byp  = wr_en_i && (wr_addr_i == rd_a);

        // Bypass data is withheld during reset because that write is being discarded.
        assign rd_data_o[k*DATA_W +: DATA_W] =
            (rd_a == '0)      ? '0        :
            (byp && !rst_i)   ? wr_data_i :
                                regs_q[rd_a];

        assign rd_busy_o[k] = busy_q[rd_a] && !byp;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb
module tb_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        rsv_en_i;
    logic [4:0]  rsv_addr_i;
    logic [5:0]  busy_cnt_o;

    int passed = 0;
    int total  = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .busy_cnt_o (busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1);
        rst_i      = rst;
        wr_en_i    = we;
        wr_addr_i  = wa;
        wr_data_i  = wd;
        rsv_en_i   = re;
        rsv_addr_i = ra;
        rd_addr_i  = {a1, a0};
    endtask

    initial begin
        // Expectations are the combinational outputs seen before the edge that commits the vector.
        //           rst   we    wa     wd            re    ra     a0     a1     e0            e1            eb     ec
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
        vecs[2]  = '{1'b1, 1'b1, 5'd2,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd2,  32'hDEADBEEF, 32'h0,        2'b01, 6'd1};
        vecs[3]  = '{1'b0, 1'b1, 5'd7,  32'h00000011, 1'b0, 5'd0,  5'd5,  5'd2,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'h00000022, 1'b0, 5'd0,  5'd7,  5'd7,  32'h00000022, 32'h00000022, 2'b00, 6'd0};
        vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd7,  32'h0,        32'h00000022, 2'b00, 6'd0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        2'b01, 6'd1};
        vecs[8]  = '{1'b0, 1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0,  5'd3,  5'd4,  32'h00000033, 32'h0,        2'b10, 6'd2};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd3,  5'd4,  32'h00000033, 32'h0,        2'b10, 6'd1};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd4,  32'h0,        32'h0,        2'b10, 6'd1};
        vecs[11] = '{1'b0, 1'b1, 5'd9,  32'h00000055, 1'b1, 5'd9,  5'd9,  5'd9,  32'h00000055, 32'h00000055, 2'b00, 6'd2};
        vecs[12] = '{1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd10, 5'd9,  5'd4,  32'h00000055, 32'h00000044, 2'b01, 6'd2};
        vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd10, 32'h00000044, 32'h0,        2'b10, 6'd2};

        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("reset_cnt",  0, {26'd0, busy_cnt_o}, 32'd0);
        check("reset_busy", 0, {30'd0, rd_busy_o},  32'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re, vecs[i].ra, vecs[i].a0, vecs[i].a1);
            #1;
            check("data0", i, rd_data_o[31:0],     vecs[i].e0);
            check("data1", i, rd_data_o[63:32],    vecs[i].e1);
            check("busy",  i, {30'd0, rd_busy_o},  {30'd0, vecs[i].eb});
            check("cnt",   i, {26'd0, busy_cnt_o}, {26'd0, vecs[i].ec});
        end

        // Fill the scoreboard: r9 and r10 are already busy, so the count tops out at 31.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_i);
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd0, 5'd0);
        end
        @(negedge clk_i);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd1);
        #1;
        check("full_cnt",  0, {26'd0, busy_cnt_o}, 32'd31);
        check("full_busy", 0, {30'd0, rd_busy_o},  32'd3);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd0);
        #1;
        check("nowrap_cnt",  0, {26'd0, busy_cnt_o}, 32'd31);
        check("nowrap_busy", 0, {30'd0, rd_busy_o},  32'd1);

        @(negedge clk_i);
        drive(1'b1, 1'b1, 5'd2, 32'h0000ABCD, 1'b0, 5'd0, 5'd2, 5'd2);
        #1;
        check("rst_byp_data", 0, rd_data_o[31:0], 32'h0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd9);
        #1;
        check("flush_cnt",   0, {26'd0, busy_cnt_o}, 32'd0);
        check("flush_r2",    0, rd_data_o[31:0],     32'h0);
        check("flush_r9",    0, rd_data_o[63:32],    32'h0);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_i);
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            #1;
            check("flush_busy", i, {30'd0, rd_busy_o}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU core. It replaces the fixed 32x32, 2-read/1-write file.
- Configurable data width, register count and number of read ports.
- Same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits) with an occupancy counter, so decode can detect RAW hazards on in-flight producers.
- Sits between ID (reads, reservations) and WB (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; register count = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active high
rd_addr_i  input  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data_o  output  NUM_RD*DATA_W  packed read data, combinational
rd_busy_o  output  NUM_RD  per-port "value not yet available", combinational
wr_en_i  input  1  WB write strobe
wr_addr_i  input  ADDR_W  WB destination
wr_data_i  input  DATA_W  WB data
rsv_en_i  input  1  ID reserves a destination (producer issued)
rsv_addr_i  input  ADDR_W  reserved destination
busy_cnt_o  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset: on a posedge with rst_i=1:
  - all registers become 0, all busy bits become 0, busy_cnt_o becomes 0.
  - wr_en_i and rsv_en_i in that cycle are discarded.
  - Reset applied mid-operation simply flushes all pending reservations.
- Register 0:
  - always reads 0 and is never busy.
  - writes and reservations to address 0 are ignored and do not change busy_cnt_o.
- Write: on a posedge with wr_en_i=1, rst_i=0 and wr_addr_i!=0, the register takes wr_data_i.
- Read: rd_data_o port k is combinational, with priority:
  1. addr==0 -> 0
  2. wr_en_i && wr_addr_i==addr -> wr_data_i (bypass)
  3. otherwise the stored value.
  - The bypass is suppressed while rst_i=1.
- Read busy:
  - rd_busy_o[k] = busy[addr] && !(wr_en_i && wr_addr_i==addr).
  - A value being written this cycle is therefore reported available.
- Scoreboard update at each posedge (rst_i=0):
  - wr_en_i clears busy[wr_addr_i].
  - rsv_en_i sets busy[rsv_addr_i].
  - Same nonzero address for both: set wins (a new producer supersedes). The bit stays 1 and the counter is unchanged.
  - Reserving an already-busy register: no counter change.
  - Writing a non-busy register: data is stored, no counter change.
- busy_cnt_o:
  - registered; equals the popcount of the busy bits after every edge.
  - Per-cycle delta is in {-1, 0, +1}, computed from actual bit transitions.
  - Maximum value 2**ADDR_W-1; it never wraps.
- All read ports are independent; any ports may alias the same address.
- Latency: write visible through the bypass in the same cycle and from storage the next cycle. Reservation visible on rd_busy_o the next cycle.

Test Plan:
- Reset sweep: write 0xDEADBEEF to r5, then rst_i=1 for one cycle -> r5 reads 0, busy_cnt_o=0, every rd_busy_o=0.
- Bypass: with r7=0x11, in one cycle wr_en_i=1, wr_addr_i=7, wr_data_i=0x22 and rd_addr port0=7 -> rd_data_o port0=0x22 and rd_busy_o[0]=0 in that cycle; port1=7 on the next cycle -> 0x22.
- Register 0: write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rd_busy_o=0, busy_cnt_o unchanged.
- Scoreboard:
  - reserve r3, r4 -> busy_cnt_o=2, reads of r3 report busy.
  - write r3 -> busy_cnt_o=1.
  - re-reserve r4 -> busy_cnt_o still 1.
- Simultaneous: r9 busy; same cycle wr_en_i to r9 (0x55) and rsv_en_i to r9 -> r9=0x55, r9 still busy, busy_cnt_o unchanged.
- Reset mid-operation: reserve 31 registers (busy_cnt_o=31, no wrap), then rst_i=1 together with wr_en_i to r2 -> all busy clear, r2=0, busy_cnt_o=0.
